// File: rtl/quad_rr_arbiter_pkg.sv
// Shared constants and types for the quad round-robin arbiter.
// Requester count, data width, index type, pointer reset value and a one-hot helper.
package quad_rr_arbiter_pkg;

  localparam int REQ_N  = 4;
  localparam int DATA_W = 4;

  typedef logic [1:0] idx_t;

  // Pointer resets to 3 so that requester 0 is searched first.
  localparam idx_t PTR_RST = 2'd3;

  function automatic logic [REQ_N-1:0] onehot(input idx_t i);
    onehot = 4'b0001 << i;
  endfunction

endpackage

// File: rtl/quad_rr_arbiter_mux.sv
// Quad 4-bit 4:1 data mux: S selects InA (0) through InD (3).
module quad_rr_arbiter_mux
  import quad_rr_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] InA,
  input  logic [DATA_W-1:0] InB,
  input  logic [DATA_W-1:0] InC,
  input  logic [DATA_W-1:0] InD,
  input  idx_t              S,
  output logic [DATA_W-1:0] Y
);

  // Select one requester's data by index.
  always_comb begin
    Y = InA;
    case (S)
      2'd0:    Y = InA;
      2'd1:    Y = InB;
      2'd2:    Y = InC;
      2'd3:    Y = InD;
      default: Y = InA;
    endcase
  end

endmodule

// File: rtl/quad_rr_arbiter.sv
// Four-requester round-robin arbiter with a one-beat registered output stage.
// Optional grant locking is enabled by defining QUAD_ARB_LOCK_EN.
module quad_rr_arbiter
  import quad_rr_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_N-1:0]  req,
  input  logic [REQ_N-1:0]  lock,
  input  logic [DATA_W-1:0] InA,
  input  logic [DATA_W-1:0] InB,
  input  logic [DATA_W-1:0] InC,
  input  logic [DATA_W-1:0] InD,
  output logic [REQ_N-1:0]  gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output idx_t              out_src
);

  idx_t              r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  idx_t              r_out_src;

  logic              w_accept;
  logic              w_found;
  idx_t              w_rr_winner;
  idx_t              w_winner;
  logic [DATA_W-1:0] w_mux_data;

  // Gated by rst_n so that no grant is issued during reset cycles.
  assign w_accept = rst_n && (|req) && (!r_out_valid || out_ready);

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_rr_winner = r_ptr;
    w_found     = 1'b0;
    for (int k = 1; k <= REQ_N; k++) begin
      idx_t cand;
      cand = r_ptr + idx_t'(k);
      if (!w_found && req[cand]) begin
        w_rr_winner = cand;
        w_found     = 1'b1;
      end else begin
        w_found     = w_found;
      end
    end
  end

`ifdef QUAD_ARB_LOCK_EN
  logic [3:0] r_lock_cnt;
  logic       w_lock_win;

  assign w_lock_win = req[r_ptr] && lock[r_ptr] && (r_lock_cnt < 4'(LOCK_MAX));
  assign w_winner   = w_lock_win ? r_ptr : w_rr_winner;

  // Count consecutive locked wins; any plain round-robin win clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_cnt <= 4'd0;
    end else if (w_accept) begin
      r_lock_cnt <= w_lock_win ? (r_lock_cnt + 4'd1) : 4'd0;
    end else begin
      r_lock_cnt <= r_lock_cnt;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^{lock, 4'(LOCK_MAX)};
  assign w_winner      = w_rr_winner;
`endif

  // Grant is one-hot on the winner only when a beat is being accepted.
  always_comb begin
    if (w_accept) begin
      gnt = onehot(w_winner);
    end else begin
      gnt = 4'b0000;
    end
  end

  quad_rr_arbiter_mux u_mux (
    .InA (InA),
    .InB (InB),
    .InC (InC),
    .InD (InD),
    .S   (w_winner),
    .Y   (w_mux_data)
  );

  // Output stage and pointer: load on accept, clear valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_src   <= 2'd0;
      r_ptr       <= PTR_RST;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_winner;
      r_ptr       <= w_winner;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: doc/quad_rr_arbiter.md
QUAD_RR_ARBITER -- requirements
Module: quad_rr_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 4, max consecutive locked grants to one requester (1..15); used only when QUAD_ARB_LOCK_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 req  input  4  req[i] = requester i presents valid data.
REQ-005 lock  input  4  lock[i] = requester i asks to keep the grant on its next beat.
REQ-006 InA, InB, InC, InD  input  4 each  data of requesters 0, 1, 2, 3.
REQ-007 gnt  output  4  one-hot or zero, combinational; gnt[i]=1 means requester i's data is accepted this cycle.
REQ-008 out_valid  output  1  registered; out_data/out_src hold a beat.
REQ-009 out_ready  input  1  downstream accepts the beat when out_valid && out_ready.
REQ-010 out_data  output  4  registered data of the accepted beat.
REQ-011 out_src  output  2  registered index of the requester that sourced out_data.

Function
REQ-012 accept = (|req) && (!out_valid || out_ready); gnt shall be 4'b0000 when accept=0.
REQ-013 When accept=1, exactly one gnt bit shall be set, chosen round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4), first requester with req set wins.
REQ-014 On an accept cycle, the winner index shall drive the 2-bit select S of the data mux (0→InA … 3→InD); the next edge shall load out_data with the mux output, out_src with the winner, and out_valid with 1.
REQ-015 On an accept cycle, ptr shall load the winner index on the next edge; otherwise ptr shall hold.
REQ-016 Latency: data accepted in cycle N shall appear on out_data with out_valid=1 in cycle N+1.
REQ-017 Throughput: when out_ready stays 1, one beat per cycle shall be accepted, with no bubble.
REQ-018 Stall: when out_valid=1 and out_ready=0, out_data, out_src, out_valid and ptr shall hold, and gnt shall be 0.
REQ-019 Drain: when out_valid=1, out_ready=1 and req=0, out_valid shall clear on the next edge; out_data and out_src shall hold their last values.
REQ-020 Simultaneous drain and accept in one cycle shall replace the beat, with out_valid remaining 1.
REQ-021 ptr wrap-around: a winner of 3 shall make requester 0 first in the next search.
REQ-022 req may change in any cycle; the arbiter shall make no fairness promise for a request withdrawn before it is granted.

Reset
REQ-023 When rst_n=0 at an edge: out_valid=0, out_data=4'h0, out_src=2'd0, ptr=2'd3 (requester 0 highest priority first), lock counter=0.
REQ-024 Reset shall override any in-flight beat; the beat shall be lost, and gnt shall be 0 during reset cycles.

Configuration
REQ-025 Macro QUAD_ARB_LOCK_EN, defined: if req[ptr] && lock[ptr] && lock counter < LOCK_MAX, requester ptr shall win regardless of round-robin.
REQ-026 The counter shall increment on each locked win and clear on any non-locked win.
REQ-027 Once the counter reaches LOCK_MAX, the next accept shall use plain round-robin, which forces rotation when another requester is pending.
REQ-028 Macro QUAD_ARB_LOCK_EN, undefined: the lock port shall remain present but be ignored, no counter shall be built, and behaviour shall be pure round-robin.

Structure
REQ-029 A shared package shall hold: requester count (4), data width (4), the 2-bit index type, and the reset value of ptr.
REQ-030 The datapath shall be one instance of the existing 4-bit quad 4:1 mux module, driven by the winner index; there shall be no other sub-module.
REQ-031 Priority search and lock logic shall be combinational within quad_rr_arbiter, with out_* registers fed from the mux output.

Verification
REQ-032 Reset then req=4'b1111, out_ready=1, InA..InD=1,2,3,4: gnt sequence 0001,0010,0100,1000,0001; out_data 1,2,3,4,1, each one cycle after its grant.
REQ-033 req=4'b1010, out_ready=0 after the first accept: gnt=0010 once, out_data holds InB and out_src=1 for all stalled cycles; on out_ready=1, next gnt=1000.
REQ-034 Single requester req=4'b1000, out_ready=1 for 3 cycles: gnt=1000 every cycle, ptr stays 3, no bubbles; then req=0: out_valid drops after one cycle.
REQ-035 rst_n=0 asserted while out_valid=1, out_ready=0: next cycle out_valid=0, out_data=0; after release, req=4'b1111 grants requester 0 first.
REQ-036 With QUAD_ARB_LOCK_EN, LOCK_MAX=2, req=4'b0011, lock=4'b0001, out_ready=1: gnt 0001,0001,0001,0010 (initial win plus 2 locked, then forced rotation).
REQ-037 Without QUAD_ARB_LOCK_EN, same stimulus as REQ-036: gnt alternates 0001,0010,0001,0010.
